// File: rtl/lift_pkg.sv
// Shared lift types: scheduler states, sweep direction, default sizes.
// Imported by the scheduler, its target picker and the lift controller.
package lift_pkg;

    localparam int NUM_FLOORS_DEF = 16;
    localparam int FLOOR_W_DEF    = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SELECT = 2'b01,
        ST_OFFER  = 2'b10,
        ST_SERVE  = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10
    } dir_t;

endpackage

// File: rtl/lift_target_picker.sv
// Combinational sweep picker: chooses the next floor to serve and the
// resulting direction from the pending request bitmaps.
module lift_target_picker
    import lift_pkg::*;
#(
    parameter int NUM_FLOORS = NUM_FLOORS_DEF,
    parameter int FLOOR_W    = FLOOR_W_DEF
) (
    input  logic [NUM_FLOORS-1:0] i_up,
    input  logic [NUM_FLOORS-1:0] i_down,
    input  logic [NUM_FLOORS-1:0] i_car,
    input  logic [FLOOR_W-1:0]    i_curr_floor,
    input  logic [1:0]            i_dir,
    output logic [FLOOR_W-1:0]    o_target,
    output logic [1:0]            o_dir,
    output logic                  o_found
);

    logic [NUM_FLOORS-1:0] w_all;
    logic                  w_at;
    logic                  w_has_a;
    logic                  w_has_b;
    logic [FLOOR_W-1:0]    w_above;
    logic [FLOOR_W-1:0]    w_below;
    logic [FLOOR_W-1:0]    w_da;
    logic [FLOOR_W-1:0]    w_db;

    assign w_all = i_up | i_down | i_car;

    // Descending scan leaves the closest floor above; ascending the closest below.
    always_comb begin
        w_at    = 1'b0;
        w_has_a = 1'b0;
        w_has_b = 1'b0;
        w_above = '0;
        w_below = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (w_all[i] && (FLOOR_W'(i) > i_curr_floor)) begin
                w_has_a = 1'b1;
                w_above = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (w_all[i] && (FLOOR_W'(i) < i_curr_floor)) begin
                w_has_b = 1'b1;
                w_below = FLOOR_W'(i);
            end
            if (w_all[i] && (FLOOR_W'(i) == i_curr_floor)) begin
                w_at = 1'b1;
            end
        end
    end

    assign w_da = w_above - i_curr_floor;
    assign w_db = i_curr_floor - w_below;

    always_comb begin
        o_target = i_curr_floor;
        o_dir    = i_dir;
        o_found  = 1'b1;
        if (!w_at) begin
            case (i_dir)
                DIR_UP: begin
                    if (w_has_a) begin
                        o_target = w_above;
                    end else if (w_has_b) begin
                        o_target = w_below;
                        o_dir    = DIR_DOWN;
                    end else begin
                        o_found  = 1'b0;
                    end
                end
                DIR_DOWN: begin
                    if (w_has_b) begin
                        o_target = w_below;
                    end else if (w_has_a) begin
                        o_target = w_above;
                        o_dir    = DIR_UP;
                    end else begin
                        o_found  = 1'b0;
                    end
                end
                default: begin
                    // Equal distance favours the upper floor.
                    if (w_has_a && (!w_has_b || (w_da <= w_db))) begin
                        o_target = w_above;
                        o_dir    = DIR_UP;
                    end else if (w_has_b) begin
                        o_target = w_below;
                        o_dir    = DIR_DOWN;
                    end else begin
                        o_found  = 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/lift_request_scheduler.sv
// Lift request scheduler: latches hall/car calls, offers the next sweep
// target over a valid/ready handshake and clears calls on arrival.
module lift_request_scheduler
    import lift_pkg::*;
#(
    parameter int NUM_FLOORS = NUM_FLOORS_DEF,
    parameter int FLOOR_W    = FLOOR_W_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NUM_FLOORS-1:0] i_hall_up,
    input  logic [NUM_FLOORS-1:0] i_hall_down,
    input  logic [NUM_FLOORS-1:0] i_car_call,
    input  logic [FLOOR_W-1:0]    i_curr_floor,
    input  logic                  i_arrived,
    output logic [FLOOR_W-1:0]    o_target_floor,
    output logic                  o_target_valid,
    input  logic                  i_target_ready,
    output logic [1:0]            o_dir,
    output logic [NUM_FLOORS-1:0] o_pending
);

    localparam logic [NUM_FLOORS-1:0] L_TOP =
        NUM_FLOORS'(1) << (NUM_FLOORS - 1);
    localparam logic [NUM_FLOORS-1:0] L_BOT = NUM_FLOORS'(1);

    state_t                r_state;
    logic [NUM_FLOORS-1:0] r_up;
    logic [NUM_FLOORS-1:0] r_down;
    logic [NUM_FLOORS-1:0] r_car;
    logic [NUM_FLOORS-1:0] r_pending;
    logic [FLOOR_W-1:0]    r_target;
    logic [1:0]            r_dir;
    logic                  r_valid;

    logic [NUM_FLOORS-1:0] w_all;
    logic [NUM_FLOORS-1:0] w_tsel;
    logic [NUM_FLOORS-1:0] w_clr_up;
    logic [NUM_FLOORS-1:0] w_clr_down;
    logic [NUM_FLOORS-1:0] w_clr_car;
    logic [NUM_FLOORS-1:0] w_up_nxt;
    logic [NUM_FLOORS-1:0] w_down_nxt;
    logic [NUM_FLOORS-1:0] w_car_nxt;
    logic                  w_beyond_up;
    logic                  w_beyond_dn;
    logic                  w_arrive;
    logic [FLOOR_W-1:0]    w_pick_floor;
    logic [1:0]            w_pick_dir;
    logic                  w_pick_found;

    assign w_all    = r_up | r_down | r_car;
    assign w_arrive = (r_state == ST_SERVE) && i_arrived;

    lift_target_picker #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_picker (
        .i_up         (r_up),
        .i_down       (r_down),
        .i_car        (r_car),
        .i_curr_floor (i_curr_floor),
        .i_dir        (r_dir),
        .o_target     (w_pick_floor),
        .o_dir        (w_pick_dir),
        .o_found      (w_pick_found)
    );

    always_comb begin
        w_tsel      = '0;
        w_beyond_up = 1'b0;
        w_beyond_dn = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            w_tsel[i] = (FLOOR_W'(i) == r_target);
            if (w_all[i] && (FLOOR_W'(i) > r_target)) w_beyond_up = 1'b1;
            if (w_all[i] && (FLOOR_W'(i) < r_target)) w_beyond_dn = 1'b1;
        end
    end

    // The opposite hall call is also served when the sweep turns here.
    always_comb begin
        w_clr_up   = '0;
        w_clr_down = '0;
        w_clr_car  = '0;
        if (w_arrive) begin
            w_clr_car = w_tsel;
            case (r_dir)
                DIR_UP: begin
                    w_clr_up = w_tsel;
                    if (!w_beyond_up) w_clr_down = w_tsel;
                end
                DIR_DOWN: begin
                    w_clr_down = w_tsel;
                    if (!w_beyond_dn) w_clr_up = w_tsel;
                end
                default: begin
                    w_clr_up   = w_tsel;
                    w_clr_down = w_tsel;
                end
            endcase
        end
    end

    assign w_up_nxt   = (r_up | (i_hall_up & ~L_TOP)) & ~w_clr_up;
    assign w_down_nxt = (r_down | (i_hall_down & ~L_BOT)) & ~w_clr_down;
    assign w_car_nxt  = (r_car | i_car_call) & ~w_clr_car;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_up      <= '0;
            r_down    <= '0;
            r_car     <= '0;
            r_pending <= '0;
            r_target  <= '0;
            r_dir     <= DIR_NONE;
            r_valid   <= 1'b0;
        end else begin
            r_up      <= w_up_nxt;
            r_down    <= w_down_nxt;
            r_car     <= w_car_nxt;
            r_pending <= w_up_nxt | w_down_nxt | w_car_nxt;
            unique case (r_state)
                ST_IDLE: begin
                    if (|w_all) r_state <= ST_SELECT;
                end
                ST_SELECT: begin
                    if (w_pick_found) begin
                        r_target <= w_pick_floor;
                        r_dir    <= w_pick_dir;
                        r_valid  <= 1'b1;
                        r_state  <= ST_OFFER;
                    end else begin
                        r_dir    <= DIR_NONE;
                        r_state  <= ST_IDLE;
                    end
                end
                ST_OFFER: begin
                    if (r_valid && i_target_ready) begin
                        r_valid <= 1'b0;
                        r_state <= ST_SERVE;
                    end
                end
                ST_SERVE: begin
                    if (w_arrive) begin
                        if (|(w_up_nxt | w_down_nxt | w_car_nxt)) begin
                            r_state <= ST_SELECT;
                        end else begin
                            r_dir   <= DIR_NONE;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_target_floor = r_target;
    assign o_target_valid = r_valid;
    assign o_dir          = r_dir;
    assign o_pending      = r_pending;

endmodule

// File: tb/tb_lift_request_scheduler.sv
// Bench for lift_request_scheduler: directed scenarios plus random
// traffic, all checked against a floor-level behavioural model.
module tb_lift_request_scheduler;

    localparam int N  = 16;
    localparam int FW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  hu;
    logic [N-1:0]  hd;
    logic [N-1:0]  cc;
    logic [FW-1:0] cf;
    logic          arr;
    logic          rdy;
    logic [FW-1:0] tf;
    logic          tv;
    logic [1:0]    dir;
    logic [N-1:0]  pend;

    always #5 clk = ~clk;

    lift_request_scheduler #(
        .NUM_FLOORS (N),
        .FLOOR_W    (FW)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_hall_up      (hu),
        .i_hall_down    (hd),
        .i_car_call     (cc),
        .i_curr_floor   (cf),
        .i_arrived      (arr),
        .o_target_floor (tf),
        .o_target_valid (tv),
        .i_target_ready (rdy),
        .o_dir          (dir),
        .o_pending      (pend)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model: per-floor call flags, phase 0 idle 1 select 2 offer 3 serve.
    bit m_up[N];
    bit m_dn[N];
    bit m_car[N];
    int m_ph;
    int m_tgt;
    int m_dir;
    int m_valid;

    function automatic bit m_req(int f);
        return m_up[f] | m_dn[f] | m_car[f];
    endfunction

    function automatic bit m_any();
        for (int f = 0; f < N; f++) if (m_req(f)) return 1'b1;
        return 1'b0;
    endfunction

    // Closest requested floor on one side (+1 above, -1 below, 0 either);
    // ties resolve to the higher floor. -1 when none.
    function automatic int nearest(int c, int side);
        int best = -1;
        int bd   = 1000;
        for (int f = 0; f < N; f++) begin
            int d = (f > c) ? f - c : c - f;
            bit ok = (side > 0) ? (f > c) : (side < 0) ? (f < c) : 1'b1;
            if (m_req(f) && ok && (d < bd || (d == bd && f > best))) begin
                best = f;
                bd   = d;
            end
        end
        return best;
    endfunction

    task automatic m_pick(input int c);
        int a;
        int b;
        a = nearest(c, 1);
        b = nearest(c, -1);
        if (m_req(c)) begin
            m_tgt = c;
        end else if (m_dir == 1) begin
            if (a >= 0) m_tgt = a;
            else begin m_tgt = b; m_dir = 2; end
        end else if (m_dir == 2) begin
            if (b >= 0) m_tgt = b;
            else begin m_tgt = a; m_dir = 1; end
        end else begin
            m_tgt = nearest(c, 0);
            m_dir = (m_tgt > c) ? 1 : 2;
        end
    endtask

    task automatic m_edge();
        bit cu[N];
        bit cd[N];
        bit ccar[N];
        bit bu;
        bit bd;
        int nph;
        if (rst) begin
            for (int f = 0; f < N; f++) begin
                m_up[f] = 0; m_dn[f] = 0; m_car[f] = 0;
            end
            m_ph = 0; m_tgt = 0; m_dir = 0; m_valid = 0;
            return;
        end
        for (int f = 0; f < N; f++) begin
            cu[f] = 0; cd[f] = 0; ccar[f] = 0;
        end
        nph = m_ph;
        case (m_ph)
            0: if (m_any()) nph = 1;
            1: begin m_pick(int'(cf)); m_valid = 1; nph = 2; end
            2: if (rdy) begin nph = 3; m_valid = 0; end
            default: if (arr) begin
                bu = 0; bd = 0;
                for (int f = 0; f < N; f++) begin
                    if (m_req(f) && f > m_tgt) bu = 1;
                    if (m_req(f) && f < m_tgt) bd = 1;
                end
                ccar[m_tgt] = 1;
                if (m_dir == 1) begin
                    cu[m_tgt] = 1; if (!bu) cd[m_tgt] = 1;
                end else if (m_dir == 2) begin
                    cd[m_tgt] = 1; if (!bd) cu[m_tgt] = 1;
                end else begin
                    cu[m_tgt] = 1; cd[m_tgt] = 1;
                end
            end
        endcase
        for (int f = 0; f < N; f++) begin
            m_up[f]  = (m_up[f] | (hu[f] && f != N - 1)) & !cu[f];
            m_dn[f]  = (m_dn[f] | (hd[f] && f != 0)) & !cd[f];
            m_car[f] = (m_car[f] | cc[f]) & !ccar[f];
        end
        if (m_ph == 3 && arr) begin
            nph = m_any() ? 1 : 0;
            if (nph == 0) m_dir = 0;
        end
        m_ph = nph;
    endtask

    task automatic step();
        logic [N-1:0] ep;
        @(posedge clk);
        m_edge();
        #1;
        for (int f = 0; f < N; f++) ep[f] = m_req(f);
        chk("pending", 32'(pend), 32'(ep));
        chk("valid", 32'(tv), 32'(m_valid));
        chk("target", 32'(tf), 32'(m_tgt));
        chk("dir", 32'(dir), 32'(m_dir));
        hu = '0; hd = '0; cc = '0; arr = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        for (int k = 0; k < 20 && !tv; k++) step();
        chk({tag, "_timeout"}, 32'(tv), 32'd1);
    endtask

    task automatic serve(input int t, input int d,
                         input logic [N-1:0] press, input string tag);
        wait_valid(tag);
        chk({tag, "_tgt"}, 32'(tf), 32'(t));
        chk({tag, "_dir"}, 32'(dir), 32'(d));
        rdy = 1'b1;
        step();
        rdy = 1'b0;
        step();
        cf  = FW'(t);
        arr = 1'b1;
        cc  = press;
        step();
    endtask

    initial begin
        rst = 1'b1; hu = '0; hd = '0; cc = '0;
        cf = '0; arr = 1'b0; rdy = 1'b0;
        step();
        step();
        chk("rst_valid", 32'(tv), 32'd0);
        chk("rst_target", 32'(tf), 32'd0);
        chk("rst_dir", 32'(dir), 32'd0);
        chk("rst_pending", 32'(pend), 32'd0);
        rst = 1'b0;

        cc[5] = 1'b1;
        step();
        step();
        chk("lat_n2_valid", 32'(tv), 32'd0);
        step();
        chk("lat_n3_valid", 32'(tv), 32'd1);
        chk("lat_target", 32'(tf), 32'd5);
        chk("lat_dir", 32'(dir), 32'd1);
        rdy = 1'b1;
        step();
        cf = FW'(5); arr = 1'b1;
        step();
        rdy = 1'b0;
        chk("lat_clear5", 32'(pend[5]), 32'd0);

        rst = 1'b1; cf = '0;
        step();
        rst = 1'b0;
        cc[3] = 1'b1;
        step();
        serve(3, 1, 16'h00A2, "sweep3");
        serve(5, 1, '0, "sweep5");
        serve(7, 1, '0, "sweep7");
        serve(1, 2, '0, "sweep1");

        cc[10] = 1'b1;
        step();
        wait_valid("hold");
        cc[2] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("hold_valid", 32'(tv), 32'd1);
            chk("hold_target", 32'(tf), 32'd10);
        end
        serve(10, 1, '0, "hold10");
        serve(2, 2, '0, "hold2");

        hu[15] = 1'b1; hd[0] = 1'b1;
        step();
        for (int k = 0; k < 5; k++) begin
            chk("illegal_pend", 32'(pend), 32'd0);
            chk("illegal_valid", 32'(tv), 32'd0);
            step();
        end

        cc[4] = 1'b1;
        step();
        serve(4, 1, 16'h0010, "sameclr");
        chk("sameclr_p4", 32'(pend[4]), 32'd0);
        step();
        chk("sameclr_p4b", 32'(pend[4]), 32'd0);

        cc = 16'h1101;
        step();
        wait_valid("midrst");
        chk("midrst_tgt", 32'(tf), 32'd8);
        rdy = 1'b1;
        step();
        rdy = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_pend", 32'(pend), 32'd0);
        chk("midrst_valid", 32'(tv), 32'd0);
        chk("midrst_dir", 32'(dir), 32'd0);

        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(499) == 0);
            if ($urandom_range(2) == 0) begin
                int f = $urandom_range(N - 1);
                case ($urandom_range(2))
                    0: hu[f] = 1'b1;
                    1: hd[f] = 1'b1;
                    default: cc[f] = 1'b1;
                endcase
            end
            rdy = 1'($urandom_range(1));
            if (m_ph == 3 && $urandom_range(3) == 0) begin
                cf  = FW'(m_tgt);
                arr = 1'b1;
            end else if (m_ph != 3 && $urandom_range(49) == 0) begin
                arr = 1'b1;
            end
            if (m_ph == 0 && $urandom_range(7) == 0) begin
                cf = FW'($urandom_range(N - 1));
            end
            step();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lift_request_scheduler.md
LIFT_REQUEST_SCHEDULER -- requirements
Module: lift_request_scheduler

Interface
REQ-001 Parameter NUM_FLOORS, default 16: number of served floors, legal range 2..32.
REQ-002 Parameter FLOOR_W, default 5: floor-number width; SHALL be at least clog2(NUM_FLOORS).
REQ-003 Port i_clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 Port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port i_hall_up, input, NUM_FLOORS bits: hall up-call bitmap; bit f pulses for one cycle when pressed.
REQ-006 Port i_hall_down, input, NUM_FLOORS bits: hall down-call bitmap, same pulse rule.
REQ-007 Port i_car_call, input, NUM_FLOORS bits: in-car floor-button bitmap, same pulse rule.
REQ-008 Port i_curr_floor, input, FLOOR_W bits: current car position, reported by the lift controller.
REQ-009 Port i_arrived, input, 1 bit: one-cycle pulse from the lift controller when the car stops at o_target_floor with its door open.
REQ-010 Port o_target_floor, output, FLOOR_W bits: next floor to serve.
REQ-011 Port o_target_valid, output, 1 bit: o_target_floor is offered.
REQ-012 Port i_target_ready, input, 1 bit: lift controller accepts the target; the handshake completes when o_target_valid and i_target_ready are both 1.
REQ-013 Port o_dir, output, 2 bits: sweep direction; 00 = none, 01 = up, 10 = down.
REQ-014 Port o_pending, output, NUM_FLOORS bits: registered OR of the up, down and car request registers.

Function
REQ-015 Request latching: an input bit at 1 SHALL set the matching request register, which holds until cleared; the value is visible on o_pending the next cycle.
REQ-016 Illegal calls: i_hall_up[NUM_FLOORS-1] and i_hall_down[0] SHALL be ignored.
REQ-017 States: IDLE, SELECT, OFFER, SERVE.
REQ-018 IDLE to SELECT: the cycle after any request register is non-zero.
REQ-019 SELECT is one cycle: it computes the target and o_dir, then moves to OFFER.
REQ-020 Target rule when o_dir = up: nearest requested floor strictly above i_curr_floor; if none, the nearest below, with o_dir switched to down.
REQ-021 Target rule when o_dir = down: the mirror of REQ-020.
REQ-022 Target rule when o_dir = none: the nearest requested floor; a distance tie picks the upper floor.
REQ-023 A request at i_curr_floor SHALL be selected first, with o_dir unchanged.
REQ-024 OFFER: o_target_valid = 1, and o_target_floor and o_dir SHALL stay stable until the handshake.
REQ-025 OFFER: new requests SHALL NOT cause a retarget.
REQ-026 Handshake cycle: the state SHALL move to SERVE and o_target_valid SHALL drop the next cycle.
REQ-027 SERVE: wait for i_arrived.
REQ-028 On i_arrived, clear car_call[t] and the hall call at floor t in the direction of o_dir, where t = o_target_floor.
REQ-029 On i_arrived, also clear the opposite-direction hall call at t if no request lies beyond t in the current direction.
REQ-030 On i_arrived, clear both hall calls at t when o_dir = none.
REQ-031 After i_arrived: go to SELECT if any request remains, else to IDLE with o_dir = none.
REQ-032 Set and clear of the same bit in the same cycle: clear wins, because the door is already open at that floor.
REQ-033 i_arrived outside SERVE SHALL be ignored.
REQ-034 Latency: a first press in cycle N from IDLE SHALL give o_target_valid = 1 in cycle N+3 (N+1 latch, N+2 SELECT, N+3 OFFER).

Reset
REQ-035 On i_rst = 1, all request registers SHALL clear to 0 and the state SHALL go to IDLE.
REQ-036 Output reset values: o_target_valid = 0, o_target_floor = 0, o_dir = 00, o_pending = 0.
REQ-037 Reset mid-operation (OFFER or SERVE) SHALL drop the offered target and all pending requests without a handshake.
REQ-038 Request pulses present during reset SHALL be lost.

Structure
REQ-039 Package lift_pkg SHALL hold the state enum, the direction enum (NONE, UP, DOWN), and the NUM_FLOORS and FLOOR_W defaults, shared with the lift controller.
REQ-040 Sub-module lift_target_picker SHALL be purely combinational.
REQ-041 lift_target_picker inputs: the request bitmaps, i_curr_floor and the current direction.
REQ-042 lift_target_picker outputs: the target floor, the new direction and a found flag.

Verification
REQ-043 Reset, then i_car_call[5] pulse at floor 0 -> o_target_valid = 1 three cycles later, o_target_floor = 5, o_dir = 01; with ready held 1, i_arrived then clears o_pending[5].
REQ-044 o_dir = up at floor 3 with requests at 7, 1 and 5 -> targets issued in order 5, 7, 1, with o_dir = 10 when 1 is offered.
REQ-045 Hold i_target_ready = 0 for 10 cycles while a closer request arrives -> o_target_floor unchanged and o_target_valid held for all 10 cycles.
REQ-046 Press i_hall_up[15] and i_hall_down[0] with NUM_FLOORS = 16 -> o_pending stays 0 and the state stays IDLE.
REQ-047 i_car_call[4] in the same cycle as i_arrived at target 4 -> o_pending[4] = 0 afterwards.
REQ-048 Assert i_rst during SERVE with 3 requests pending -> next cycle o_pending = 0, o_target_valid = 0, o_dir = 00, state IDLE.
